// File: rtl/riscv_regfile64.sv
// ---------------------------------------------------------------------------
// riscv_regfile64
//   32-entry x 64-bit integer register file for the RV64 datapath. It sits
//   between decode, which reads rs1/rs2, and writeback, which writes rd.
//   x0 is hardwired to zero.
//
// Ports
//   clk  in   1     system clock, all state updates on the rising edge
//   rst  in   1     synchronous active-high reset, clears every register
//   we   in   1     write enable
//   Rw   in   5     write register index (rd)
//   Ra   in   5     read port A register index (rs1)
//   Rb   in   5     read port B register index (rs2)
//   W    in   XLEN  write data
//   A    out  XLEN  combinational read data for Ra
//   B    out  XLEN  combinational read data for Rb
//
// Build option
//   REGFILE_WRITE_BYPASS_EN : when defined, a write in flight is forwarded
//   to a read port that addresses the same register in the same cycle.
//   This removes the writeback-to-decode hazard. When undefined, a
//   same-cycle read returns the stored value from before the write.
//   Index 0 is never forwarded in either build.
// ---------------------------------------------------------------------------
module riscv_regfile64 #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] Rw,
    input  logic [$clog2(NREG)-1:0] Ra,
    input  logic [$clog2(NREG)-1:0] Rb,
    input  logic [XLEN-1:0]         W,
    output logic [XLEN-1:0]         A,
    output logic [XLEN-1:0]         B
);

    // Architectural storage. Each entry can be probed as q[i].
    logic [XLEN-1:0] q [NREG];

    // Reset takes priority over a write in the same cycle.
    // A write to x0 is dropped, so q[0] holds zero once reset has run.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                q[i] <= '0;
            end
        end else if (we && (Rw != '0)) begin
            q[Rw] <= W;
        end
    end

    // The read mux forces index 0 to zero even though q[0] is never written.
    // The forced zero keeps x0 reading as zero before the first reset.
    always_comb begin
        A = (Ra == '0) ? '0 : q[Ra];
        B = (Rb == '0) ? '0 : q[Rb];
`ifdef REGFILE_WRITE_BYPASS_EN
        // Rw != 0 together with Ra == Rw means Ra is nonzero, so x0 is
        // never forwarded.
        if (we && !rst && (Rw != '0) && (Ra == Rw)) begin
            A = W;
        end
        if (we && !rst && (Rw != '0) && (Rb == Rw)) begin
            B = W;
        end
`endif
    end

endmodule

// File: tb/tb_riscv_regfile64.sv
module tb_riscv_regfile64;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  Rw;
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic [63:0] W;
    logic [63:0] A;
    logic [63:0] B;

    int checks = 0;
    int errors = 0;

    riscv_regfile64 #(.XLEN(64), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .Rw  (Rw),
        .Ra  (Ra),
        .Rb  (Rb),
        .W   (W),
        .A   (A),
        .B   (B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an architectural array updated by the ISA rules.
    logic [63:0] m [32];
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m[i] = 64'd0;
            model_valid = 1'b1;
        end else if (we && Rw != 5'd0) begin
            m[Rw] = W;
        end
    end

    function automatic logic [63:0] model_read(input logic [4:0] idx);
        logic [63:0] v;
        if (idx == 5'd0) return 64'd0;
        v = m[idx];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (we && !rst && Rw == idx) v = W;
`endif
        return v;
    endfunction

    // Continuous compare, sampled on the falling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (A !== model_read(Ra)) begin
                errors++;
                $display("FAIL model_A t=%0t Ra=%0d actual=%h required=%h", $time, Ra, A, model_read(Ra));
            end
            checks++;
            if (B !== model_read(Rb)) begin
                errors++;
                $display("FAIL model_B t=%0t Rb=%0d actual=%h required=%h", $time, Rb, B, model_read(Rb));
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; Rw = 5'd0; Ra = 5'd0; Rb = 5'd0; W = 64'd0;

        // Reset with we low, then read two registers.
        edge_step();
        rst = 1'b0; Ra = 5'd5; Rb = 5'd31;
        #1;
        check("reset_A", A, 64'd0);
        check("reset_B", B, 64'd0);

        // Write x1 and x2 on successive edges.
        we = 1'b1; Rw = 5'd1; W = 64'h1111111111111111;
        edge_step();
        Rw = 5'd2; W = 64'h2222222222222222;
        edge_step();
        we = 1'b0; Ra = 5'd1; Rb = 5'd2;
        #1;
        check("wr_x1", A, 64'h1111111111111111);
        check("wr_x2", B, 64'h2222222222222222);

        // A write to x0 is ignored.
        we = 1'b1; Rw = 5'd0; W = 64'hFFFFFFFFFFFFFFFF;
        edge_step();
        we = 1'b0; Ra = 5'd0; Rb = 5'd0;
        #1;
        check("x0_A", A, 64'd0);
        check("x0_B", B, 64'd0);

        // A write with we low is gated off, then the write goes through.
        we = 1'b0; Rw = 5'd1; W = 64'hDEADBEEFDEADBEEF;
        edge_step();
        Ra = 5'd1;
        #1;
        check("gated_x1", A, 64'h1111111111111111);
        we = 1'b1;
        edge_step();
        we = 1'b0;
        #1;
        check("overwrite_x1", A, 64'hDEADBEEFDEADBEEF);

        // Reset has priority over a write, and a mid-run reset clears state.
        rst = 1'b1; we = 1'b1; Rw = 5'd3; W = 64'h3333333333333333;
        edge_step();
        rst = 1'b0; we = 1'b0; Ra = 5'd1; Rb = 5'd3;
        #1;
        check("midrst_x1", A, 64'd0);
        check("midrst_x3", B, 64'd0);

        // Same-cycle read and write of x4.
        Ra = 5'd4; Rw = 5'd4; we = 1'b1; W = 64'h4444444444444444;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("same_cycle_pre", A, 64'h4444444444444444);
`else
        check("same_cycle_pre", A, 64'd0);
`endif
        edge_step();
        we = 1'b0;
        #1;
        check("same_cycle_post", A, 64'h4444444444444444);

        // Two writes to x7: the later edge wins.
        we = 1'b1; Rw = 5'd7; W = 64'h0000000000000007;
        edge_step();
        W = 64'h7777000077770000;
        edge_step();
        we = 1'b0; Ra = 5'd7; Rb = 5'd7;
        #1;
        check("last_wins_A", A, 64'h7777000077770000);
        check("last_wins_B", B, 64'h7777000077770000);

        // Fill every register with a distinct pattern, then sweep both ports.
        for (int i = 0; i < 32; i++) begin
            we = 1'b1; Rw = 5'(i);
            W = {32'hA5A50000 | 32'(i), ~(32'(i) * 32'h01010101)};
            edge_step();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            Ra = 5'(i); Rb = 5'(31 - i);
            edge_step();
        end
        Ra = 5'd31; Rb = 5'd9;
        #1;
        check("fill_x31", A, {32'hA5A5001F, ~(32'd31 * 32'h01010101)});
        check("fill_x9",  B, {32'hA5A50009, ~(32'd9 * 32'h01010101)});
        Ra = 5'd0;
        #1;
        check("fill_x0", A, 64'd0);

        edge_step();
        edge_step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety bound so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
